// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end.
// Holds the datapath width, the default boot PC, the instruction size in
// bytes and the {pc, instr} fetch packet that is also consumed by decode.
package ifetch_unit_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  localparam int FETCH_PKT_W = $bits(fetch_pkt_t);

  // Instructions are word aligned; low address bits are simply dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Two-entry synchronous FIFO for fetch packets.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   flush         drops every buffered entry (wins over push/pop)
//   push          write push_data this cycle
//   push_data     packet to write
//   pop           head consumed this cycle (only meaningful while valid)
//   count         number of buffered entries, 0..2
//   valid         registered "count != 0"
//   head          registered oldest entry, stable until popped
// The producer guarantees that it never pushes into a full FIFO without
// popping in the same cycle.
module ifetch_unit_fetch_fifo
  import ifetch_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [FETCH_PKT_W-1:0] push_data,
  input  logic                   pop,
  output logic [1:0]             count,
  output logic                   valid,
  output logic [FETCH_PKT_W-1:0] head
);

  logic [FETCH_PKT_W-1:0] head_r, head_s;
  logic [FETCH_PKT_W-1:0] tail_r, tail_s;
  logic [1:0]             count_r, count_s;
  logic                   valid_r;

  // Next-state computation for the two storage slots and the occupancy.
  always_comb begin
    head_s  = head_r;
    tail_s  = tail_r;
    count_s = count_r;
    if (flush) begin
      head_s  = '0;
      tail_s  = '0;
      count_s = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_s  = push_data;
            count_s = 2'd1;
          end else begin
            tail_s  = push_data;
            count_s = 2'd2;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_s  = tail_r;
            count_s = 2'd1;
          end else begin
            count_s = 2'd0;
          end
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy and preserves order.
          if (count_r == 2'd2) begin
            head_s = tail_r;
            tail_s = push_data;
          end else begin
            head_s = push_data;
          end
        end
        default: begin
          count_s = count_r;
        end
      endcase
    end
  end

  // Storage, occupancy and the registered valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      head_r  <= head_s;
      tail_r  <= tail_s;
      count_r <= count_s;
      valid_r <= (count_s != 2'd0);
    end
  end

  assign count = count_r;
  assign valid = valid_r;
  assign head  = head_r;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch initiator for a 1-cycle-latency synchronous instruction RAM.
// Generates sequential PCs, buffers returning words in a 2-entry FIFO under a
// credit rule so the FIFO can never overflow, and presents {pc, instr} to
// decode with a valid/ready handshake. A redirect flushes everything in flight.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_addr                 registered fetch address (RAM samples every edge)
//   mem_we, mem_din          RAM write port, tied to zero
//   mem_rdata                RAM data for the address sampled last edge
//   if_valid/if_ready        handshake toward decode
//   if_pc, if_instr          presented fetch packet
//   redirect_valid/_pc       single-cycle branch/jump target request
module ifetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_din,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  import ifetch_unit_pkg::*;

  logic [XLEN-1:0]        pc_r;
  logic [XLEN-1:0]        resp_pc_r;
  logic                   issue_r;

  logic                   issue_s;
  logic                   pop_s;
  logic                   push_s;
  logic [2:0]             credit_s;
  logic [1:0]             count_s;
  logic                   fifo_valid_s;
  logic [FETCH_PKT_W-1:0] head_data_s;
  fetch_pkt_t             push_pkt_s;
  fetch_pkt_t             head_pkt_s;

  // Credit rule and response capture.
  always_comb begin
    pop_s = fifo_valid_s & if_ready;
    // Entries that will occupy the FIFO once the outstanding response lands;
    // a new request is only allowed if a slot is still guaranteed for it.
    credit_s = {1'b0, count_s} + {2'b00, issue_r} - {2'b00, pop_s};
    issue_s  = !rst && !redirect_valid && (credit_s <= 3'd1);
    // A response returning in a redirect cycle belongs to the old stream.
    push_s            = issue_r && !redirect_valid && !rst;
    push_pkt_s.pc     = resp_pc_r;
    push_pkt_s.instr  = mem_rdata;
  end

  // PC register and the record of which address the RAM is serving.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r      <= RESET_PC;
      issue_r   <= 1'b0;
      resp_pc_r <= '0;
    end else if (redirect_valid) begin
      pc_r    <= align_pc(redirect_pc);
      issue_r <= 1'b0;
    end else if (issue_s) begin
      // Wraps modulo 2^XLEN with no indication.
      pc_r      <= pc_r + XLEN'(INSTR_BYTES);
      issue_r   <= 1'b1;
      resp_pc_r <= pc_r;
    end else begin
      issue_r <= 1'b0;
    end
  end

  ifetch_unit_fetch_fifo u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data (push_pkt_s),
    .pop       (pop_s),
    .count     (count_s),
    .valid     (fifo_valid_s),
    .head      (head_data_s)
  );

  assign head_pkt_s = fetch_pkt_t'(head_data_s);

  assign mem_addr = pc_r;
  assign mem_we   = 1'b0;
  assign mem_din  = {XLEN{1'b0}};
  assign if_valid = fifo_valid_s;
  assign if_pc    = head_pkt_s.pc;
  assign if_instr = head_pkt_s.instr;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus randomized
// ready/redirect/reset traffic against a stream-level reference model.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic [31:0] ram [1024];

  int n_assert = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  // Reference model state: next PC the stream must deliver, restart age,
  // whether ready has been high ever since the restart, and stall tracking.
  logic [31:0] exp_pc    = 32'h0;
  int          age       = 100;
  bit          all_ready = 1'b0;
  bit          stall_prev = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  ifetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_din        (mem_din),
    .mem_rdata      (mem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency instruction RAM, word index from addr[11:2].
  always @(posedge clk) mem_rdata <= ram[mem_addr[11:2]];

  function automatic logic [31:0] ram_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc / 32'd4) % 32'd1024);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle (outputs + inputs in force), then advances one clock.
  task automatic tick();
    chk("mem_we", {31'd0, mem_we}, 32'd0);
    chk("mem_din", mem_din, 32'd0);
    if (stall_prev) begin
      chk("hold_valid", {31'd0, if_valid}, 32'd1);
      chk("hold_pc", if_pc, hold_pc);
      chk("hold_instr", if_instr, hold_instr);
    end
    if (age == 1 || age == 2) chk("restart_gap", {31'd0, if_valid}, 32'd0);
    else if (age >= 3 && all_ready) chk("stream_valid", {31'd0, if_valid}, 32'd1);
    if (!rst && if_valid === 1'b1 && if_ready) begin
      chk("sb_pc", if_pc, exp_pc);
      chk("sb_instr", if_instr, ram_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end
    stall_prev = !rst && !redirect_valid && (if_valid === 1'b1) && !if_ready;
    hold_pc    = if_pc;
    hold_instr = if_instr;
    if (rst) begin
      exp_pc = 32'h0000_0000; age = 1; all_ready = 1'b1;
    end else if (redirect_valid) begin
      exp_pc = {redirect_pc[31:2], 2'b00}; age = 1; all_ready = 1'b1;
    end else begin
      if (!if_ready) all_ready = 1'b0;
      if (age < 1000) age++;
    end
    @(negedge clk);
  endtask

  logic [31:0] t6_pc  [4];
  logic [31:0] t6_ins [4];

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h1000_0000 + i;
    t6_pc  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    t6_ins = '{32'h1000_03FE, 32'h1000_03FF, 32'h1000_0000, 32'h1000_0001};
    rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, 32'h0);

    // 1: streaming from reset with ready high
    for (int i = 0; i < 8; i++) begin
      chk("t1_addr", mem_addr, 32'(4 * i));
      chk("t1_valid", {31'd0, if_valid}, {31'd0, (i >= 2)});
      if (i >= 2) chk("t1_pc", if_pc, 32'(4 * (i - 2)));
      tick();
    end

    // 2: back-pressure from reset release
    rst = 1'b1; tick(); rst = 1'b0; if_ready = 1'b0;
    tick(); tick(); tick();
    for (int k = 0; k < 10; k++) begin
      chk("t2_valid", {31'd0, if_valid}, 32'd1);
      chk("t2_pc", if_pc, 32'h0);
      chk("t2_addr", mem_addr, 32'h8);
      tick();
    end
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t2_rel_valid", {31'd0, if_valid}, 32'd1);
      chk("t2_rel_pc", if_pc, 32'(4 * k));
      tick();
    end

    // 3: redirect while the FIFO is full
    rst = 1'b1; tick(); rst = 1'b0; if_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("t3_full_pc", if_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0; if_ready = 1'b1;
    chk("t3_addr", mem_addr, 32'h100);
    chk("t3_v1", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t3_v2", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t3_v3", {31'd0, if_valid}, 32'd1);
    chk("t3_pc", if_pc, 32'h100);
    chk("t3_instr", if_instr, 32'h1000_0040);
    for (int k = 0; k < 6; k++) tick();

    // 4: back-to-back redirects
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("t4_addr1", mem_addr, 32'h40);
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    chk("t4_addr2", mem_addr, 32'h80);
    chk("t4_v1", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t4_v2", {31'd0, if_valid}, 32'd0);
    tick();
    chk("t4_v3", {31'd0, if_valid}, 32'd1);
    chk("t4_pc", if_pc, 32'h80);
    for (int k = 0; k < 5; k++) tick();

    // 5: reset mid-stream with random ready
    for (int i = 0; i < 80; i++) begin
      if_ready = 1'($urandom_range(0, 1));
      if (i == 30) begin
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_valid", {31'd0, if_valid}, 32'd0);
        chk("t5_addr", mem_addr, 32'h0);
      end else begin
        redirect_valid = ($urandom_range(0, 15) == 0) && (i < 25 || i > 45);
        redirect_pc = $urandom;
        tick();
        redirect_valid = 1'b0;
      end
    end

    // 6: wrap at the top of the address space
    if_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      chk("t6_valid", {31'd0, if_valid}, 32'd1);
      chk("t6_pc", if_pc, t6_pc[k]);
      chk("t6_instr", if_instr, t6_ins[k]);
      tick();
    end

    // Random stress: ready, redirects and occasional resets
    for (int i = 0; i < 400; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      redirect_valid = !rst && ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    n_assert++;
    assert (n_deliv > 200) else begin
      n_fail++;
      $error("FAIL deliveries observed=%0d expected>200", n_deliv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
